// File: rtl/tbl_init_sequencer.sv
// Table initialisation sequencer: walks BTB, BHT and register-file entries in order
// and writes a mode-selected initial value into each, with stall, abort and done handshake.
module tbl_init_sequencer #(
   parameter int                BTB_AW  = 8,
   parameter int                BTB_DW  = 40,
   parameter int                BHT_AW  = 8,
   parameter int                BHT_DW  = 2,
   parameter logic [BHT_DW-1:0] BHT_RST = 2'b01,
   parameter int                REG_AW  = 5,
   parameter int                REG_DW  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [2:0]        chan_en,
   input  logic              stall,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              btb_we,
   output logic [BTB_AW-1:0] btb_addr,
   output logic [BTB_DW-1:0] btb_init,
   output logic              bht_we,
   output logic [BHT_AW-1:0] bht_addr,
   output logic [BHT_DW-1:0] bht_init,
   output logic              reg_we,
   output logic [REG_AW-1:0] reg_addr,
   output logic [REG_DW-1:0] reg_init,
   output logic [2:0]        dbg_state
);

   localparam int CW0 = (BTB_AW > BHT_AW) ? BTB_AW : BHT_AW;
   localparam int CW  = (CW0 > REG_AW) ? CW0 : REG_AW;

   typedef enum logic [2:0] {S_IDLE, S_BTB, S_BHT, S_REG, S_FIN} state_t;

   // Handshake: start is sampled only in IDLE; a table write is accepted on any edge with
   // stall low; abort while busy returns to IDLE without done; done is a single-cycle pulse.

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              wrap_q, wrap_d;
   logic [1:0]        mode_q, mode_d;
   logic [2:0]        en_q, en_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic              btb_we_q, btb_we_d, bht_we_q, bht_we_d, reg_we_q, reg_we_d;
   logic [BTB_AW-1:0] btb_addr_q, btb_addr_d;
   logic [BTB_DW-1:0] btb_init_q, btb_init_d;
   logic [BHT_AW-1:0] bht_addr_q, bht_addr_d;
   logic [BHT_DW-1:0] bht_init_q, bht_init_d;
   logic [REG_AW-1:0] reg_addr_q, reg_addr_d;
   logic [REG_DW-1:0] reg_init_q, reg_init_d;

   state_t            ph;
   logic [1:0]        act_mode;
   logic [2:0]        act_en;
   logic [CW-1:0]     last;

   function automatic state_t next_phase(input logic [2:0] en, input state_t from);
      next_phase = S_FIN;
      case (from)
         S_IDLE: begin
            if (en[0])      next_phase = S_BTB;
            else if (en[1]) next_phase = S_BHT;
            else if (en[2]) next_phase = S_REG;
         end
         S_BTB: begin
            if (en[1])      next_phase = S_BHT;
            else if (en[2]) next_phase = S_REG;
         end
         S_BHT: begin
            if (en[2])      next_phase = S_REG;
         end
         default: next_phase = S_FIN;
      endcase
   endfunction

   // Address pattern is zero-extended or truncated to the table's data width.
   function automatic logic [BTB_DW-1:0] btb_val(input logic [1:0] m, input logic [BTB_AW-1:0] a);
      logic [BTB_DW+BTB_AW-1:0] ext;
      ext     = {{BTB_DW{1'b0}}, a};
      btb_val = (m == 2'd2) ? ext[BTB_DW-1:0] : '0;
   endfunction

   function automatic logic [BHT_DW-1:0] bht_val(input logic [1:0] m, input logic [BHT_AW-1:0] a);
      logic [BHT_DW+BHT_AW-1:0] ext;
      ext = {{BHT_DW{1'b0}}, a};
      if (m == 2'd2)      bht_val = ext[BHT_DW-1:0];
      else if (m == 2'd1) bht_val = BHT_RST;
      else                bht_val = '0;
   endfunction

   function automatic logic [REG_DW-1:0] reg_val(input logic [1:0] m, input logic [REG_AW-1:0] a);
      logic [REG_DW+REG_AW-1:0] ext;
      ext     = {{REG_DW{1'b0}}, a};
      reg_val = (m == 2'd2) ? ext[REG_DW-1:0] : '0;
   endfunction

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wrap_d     = 1'b0;
      mode_d     = mode_q;
      en_d       = en_q;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      btb_we_d   = 1'b0;
      btb_addr_d = '0;
      btb_init_d = '0;
      bht_we_d   = 1'b0;
      bht_addr_d = '0;
      bht_init_d = '0;
      reg_we_d   = 1'b0;
      reg_addr_d = '0;
      reg_init_d = '0;
      ph         = S_IDLE;
      act_mode   = mode_q;
      act_en     = en_q;
      last       = '0;

      // ph is the phase whose action is carried out on this edge; wrap_q means the
      // previous edge wrote the last entry of state_q, so this edge moves on.
      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               mode_d   = mode;
               en_d     = chan_en;
               act_mode = mode;
               act_en   = chan_en;
               ph       = next_phase(chan_en, S_IDLE);
            end
         end
         S_BTB, S_BHT, S_REG: begin
            if (abort) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (wrap_q) begin
               ph = next_phase(act_en, state_q);
            end else begin
               ph = state_q;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (ph == S_FIN) begin
         state_d = S_FIN;
         done_d  = 1'b1;
      end else if (ph != S_IDLE) begin
         state_d = ph;
         busy_d  = 1'b1;
         case (ph)
            S_BTB: begin
               last       = CW'({BTB_AW{1'b1}});
               btb_we_d   = !stall;
               btb_addr_d = stall ? btb_addr_q : cnt_q[BTB_AW-1:0];
               btb_init_d = stall ? btb_init_q : btb_val(act_mode, cnt_q[BTB_AW-1:0]);
            end
            S_BHT: begin
               last       = CW'({BHT_AW{1'b1}});
               bht_we_d   = !stall;
               bht_addr_d = stall ? bht_addr_q : cnt_q[BHT_AW-1:0];
               bht_init_d = stall ? bht_init_q : bht_val(act_mode, cnt_q[BHT_AW-1:0]);
            end
            default: begin
               last       = CW'({REG_AW{1'b1}});
               reg_we_d   = !stall;
               reg_addr_d = stall ? reg_addr_q : cnt_q[REG_AW-1:0];
               reg_init_d = stall ? reg_init_q : reg_val(act_mode, cnt_q[REG_AW-1:0]);
            end
         endcase
         if (!stall) begin
            if (cnt_q == last) begin
               cnt_d  = '0;
               wrap_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         wrap_q     <= 1'b0;
         mode_q     <= '0;
         en_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         btb_we_q   <= 1'b0;
         btb_addr_q <= '0;
         btb_init_q <= '0;
         bht_we_q   <= 1'b0;
         bht_addr_q <= '0;
         bht_init_q <= '0;
         reg_we_q   <= 1'b0;
         reg_addr_q <= '0;
         reg_init_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wrap_q     <= wrap_d;
         mode_q     <= mode_d;
         en_q       <= en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         btb_we_q   <= btb_we_d;
         btb_addr_q <= btb_addr_d;
         btb_init_q <= btb_init_d;
         bht_we_q   <= bht_we_d;
         bht_addr_q <= bht_addr_d;
         bht_init_q <= bht_init_d;
         reg_we_q   <= reg_we_d;
         reg_addr_q <= reg_addr_d;
         reg_init_q <= reg_init_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign btb_we    = btb_we_q;
   assign btb_addr  = btb_addr_q;
   assign btb_init  = btb_init_q;
   assign bht_we    = bht_we_q;
   assign bht_addr  = bht_addr_q;
   assign bht_init  = bht_init_q;
   assign reg_we    = reg_we_q;
   assign reg_addr  = reg_addr_q;
   assign reg_init  = reg_init_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_tbl_init_sequencer.sv
// Directed bench for tbl_init_sequencer: table of full-sequence vectors checked against a
// write scoreboard, plus hand-written abort and mid-sequence reset sequences.
module tb_tbl_init_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  mode;
   logic [2:0]  chan_en;
   logic        stall;
   logic        abort;
   logic        busy, done;
   logic        btb_we, bht_we, reg_we;
   logic [7:0]  btb_addr, bht_addr;
   logic [39:0] btb_init;
   logic [1:0]  bht_init;
   logic [4:0]  reg_addr;
   logic [31:0] reg_init;
   logic [2:0]  dbg_state;

   int tests = 0;
   int fails = 0;

   // Scoreboard entry: {table[1:0], addr[7:0], data[39:0]}; table 0 BTB, 1 BHT, 2 REG.
   logic [49:0] exp_q[$];

   typedef struct {
      logic [1:0] mode;
      logic [2:0] en;
      int         stall_tbl;
      int         stall_addr;
      int         stall_len;
      int         exp_busy;
      int         exp_done;
   } vec_t;

   vec_t vecs[6];

   tbl_init_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .chan_en(chan_en),
      .stall(stall), .abort(abort), .busy(busy), .done(done),
      .btb_we(btb_we), .btb_addr(btb_addr), .btb_init(btb_init),
      .bht_we(bht_we), .bht_addr(bht_addr), .bht_init(bht_init),
      .reg_we(reg_we), .reg_addr(reg_addr), .reg_init(reg_init),
      .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      tests++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   function automatic logic [39:0] model(input int t, input logic [1:0] m, input int a);
      logic [39:0] d;
      d = '0;
      if (m == 2'd2) d = (t == 1) ? 40'(a % 4) : 40'(a);
      else if (m == 2'd1 && t == 1) d = 40'h1;
      return d;
   endfunction

   function automatic logic [49:0] observed();
      if (btb_we)      return {2'd0, btb_addr, btb_init};
      else if (bht_we) return {2'd1, bht_addr, 38'd0, bht_init};
      else             return {2'd2, 3'd0, reg_addr, 8'd0, reg_init};
   endfunction

   // driver: full sequence for one vector, random start pulses while busy
   task automatic run_vec(input int idx, input vec_t v);
      int          busy_n, done_n, done_at, stall_left, nwe, limit;
      logic        was_stalled;
      logic [49:0] obs, exp_e;
      exp_q.delete();
      for (int t = 0; t < 3; t++)
         if (v.en[t])
            for (int a = 0; a < ((t == 2) ? 32 : 256); a++)
               exp_q.push_back({2'(t), 8'(a), model(t, v.mode, a)});
      busy_n = 0; done_n = 0; done_at = 0; stall_left = 0;
      obs = '0;
      @(negedge clk);
      start = 1'b1; mode = v.mode; chan_en = v.en; stall = 1'b0;
      @(negedge clk);
      start = 1'b0; mode = ~v.mode; chan_en = ~v.en;
      limit = v.exp_done + 3;
      for (int c = 1; c <= limit; c++) begin
         was_stalled = stall;
         nwe = int'(btb_we) + int'(bht_we) + int'(reg_we);
         if (nwe > 1) check($sformatf("v%0d_one_we_c%0d", idx, c), 64'(nwe), 64'd1);
         if (was_stalled) check($sformatf("v%0d_stall_no_we_c%0d", idx, c), 64'(nwe), 64'd0);
         if (busy) busy_n++;
         if (done) begin done_n++; done_at = c; end
         if (nwe == 1) begin
            obs = observed();
            if (exp_q.size() == 0) check($sformatf("v%0d_extra_write_c%0d", idx, c), 64'd1, 64'd0);
            else begin
               exp_e = exp_q.pop_front();
               check($sformatf("v%0d_write_c%0d", idx, c), 64'(obs), 64'(exp_e));
            end
         end
         if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) stall = 1'b0;
         end else if (v.stall_len > 0 && nwe == 1 && !was_stalled &&
                      obs[49:48] == 2'(v.stall_tbl) && obs[47:40] == 8'(v.stall_addr)) begin
            stall = 1'b1;
            stall_left = v.stall_len;
         end
         start   = busy && ($urandom_range(0, 3) == 0);
         mode    = 2'($urandom_range(0, 3));
         chan_en = 3'($urandom_range(0, 7));
         @(negedge clk);
      end
      start = 1'b0; stall = 1'b0;
      check($sformatf("v%0d_busy_cycles", idx), 64'(busy_n), 64'(v.exp_busy));
      check($sformatf("v%0d_done_cycle", idx), 64'(done_at), 64'(v.exp_done));
      check($sformatf("v%0d_done_pulses", idx), 64'(done_n), 64'd1);
      check($sformatf("v%0d_missing_writes", idx), 64'(exp_q.size()), 64'd0);
   endtask

   task automatic wait_write(input int tbl, input int addr, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 700 && !ok; c++) begin
         @(negedge clk);
         if (tbl == 0 && btb_we && btb_addr == 8'(addr)) ok = 1'b1;
         if (tbl == 1 && bht_we && bht_addr == 8'(addr)) ok = 1'b1;
      end
      check($sformatf("wait_write_t%0d_a%0d", tbl, addr), 64'(ok), 64'd1);
   endtask

   task automatic check_quiet(input string name, input int cycles);
      int act;
      act = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (btb_we || bht_we || reg_we || done || busy) act++;
      end
      check(name, 64'(act), 64'd0);
   endtask

   initial begin
      bit ok;
      vecs[0] = '{mode: 2'd1, en: 3'b111, stall_tbl: 0, stall_addr: 0,   stall_len: 0, exp_busy: 544, exp_done: 545};
      vecs[1] = '{mode: 2'd2, en: 3'b100, stall_tbl: 0, stall_addr: 0,   stall_len: 0, exp_busy: 32,  exp_done: 33};
      vecs[2] = '{mode: 2'd2, en: 3'b010, stall_tbl: 1, stall_addr: 9,   stall_len: 3, exp_busy: 259, exp_done: 260};
      vecs[3] = '{mode: 2'd0, en: 3'b000, stall_tbl: 0, stall_addr: 0,   stall_len: 0, exp_busy: 0,   exp_done: 1};
      vecs[4] = '{mode: 2'd3, en: 3'b001, stall_tbl: 0, stall_addr: 0,   stall_len: 0, exp_busy: 256, exp_done: 257};
      vecs[5] = '{mode: 2'd2, en: 3'b101, stall_tbl: 0, stall_addr: 255, stall_len: 2, exp_busy: 290, exp_done: 291};

      rst = 1'b0; start = 1'b0; mode = 2'd0; chan_en = 3'd0; stall = 1'b0; abort = 1'b0;
      #1;
      check("rst_busy_done", 64'({busy, done}), 64'd0);
      check("rst_we", 64'({btb_we, bht_we, reg_we}), 64'd0);
      check("rst_btb", 64'({btb_addr, btb_init}), 64'd0);
      check("rst_bht_reg", 64'({bht_addr, bht_init, reg_addr, reg_init}), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

      // abort mid-BTB, then restart from BTB addr 0
      start = 1'b1; mode = 2'd2; chan_en = 3'b111;
      @(negedge clk);
      start = 1'b0;
      wait_write(0, 100, ok);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_we_done", 64'({btb_we, bht_we, reg_we, done}), 64'd0);
      check("abort_btb_addr", 64'(btb_addr), 64'd0);
      check_quiet("abort_quiet", 10);
      start = 1'b1; mode = 2'd2; chan_en = 3'b111;
      @(negedge clk);
      start = 1'b0;
      check("restart_first", 64'({busy, btb_we, btb_addr, btb_init}), {22'd0, 2'b11, 8'd0, 40'd0});
      @(negedge clk);
      check("restart_second", 64'({btb_we, btb_addr, btb_init}), {15'd0, 1'b1, 8'd1, 40'd1});
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort2_busy", 64'(busy), 64'd0);

      // start and abort together in IDLE: no start
      start = 1'b1; abort = 1'b1; chan_en = 3'b111;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check_quiet("start_abort_idle", 5);

      // asynchronous reset during the BHT phase
      start = 1'b1; mode = 2'd1; chan_en = 3'b111;
      @(negedge clk);
      start = 1'b0;
      wait_write(1, 50, ok);
      rst = 1'b0; start = 1'b1;
      #1;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_bht", 64'({bht_we, bht_addr, bht_init}), 64'd0);
      check("midrst_others", 64'({btb_we, reg_we, done, btb_addr, reg_addr}), 64'd0);
      check_quiet("midrst_start_ignored", 3);
      start = 1'b0; rst = 1'b1;
      check_quiet("after_rst_idle", 4);
      run_vec(6, vecs[1]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
